// File: rtl/elastic_shift_pipe.sv
// rtl/elastic_shift_pipe.sv - elastic multi-stage pipeline that left-shifts each word
// Each stage is either a main+skid pair with a registered ready, or a single register with pass-through ready.
module elastic_shift_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2,
   parameter int SHIFT  = 2,
   parameter int SKID   = 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [WIDTH-1:0]                   t0_data,
   input  logic                               t0_valid,
   output logic                               t0_ready,
   output logic [WIDTH-1:0]                   i0_data,
   output logic                               i0_valid,
   input  logic                               i0_ready,
   input  logic                               flush,
   output logic [$clog2(2*STAGES+1)-1:0]      occupancy,
   output logic [15:0]                        xfer_count
);

   localparam int OW = $clog2(2*STAGES+1);

   logic [STAGES-1:0] main_valid_q, main_valid_d;
   logic [STAGES-1:0] skid_valid_q, skid_valid_d;
   logic [STAGES-1:0] rdy_q, rdy_d;
   logic [WIDTH-1:0]  main_data_q [STAGES];
   logic [WIDTH-1:0]  main_data_d [STAGES];
   logic [WIDTH-1:0]  skid_data_q [STAGES];
   logic [WIDTH-1:0]  skid_data_d [STAGES];
   logic [15:0]       xfer_q, xfer_d;

   logic [STAGES-1:0] up_valid;
   logic [WIDTH-1:0]  up_data [STAGES];
   logic [STAGES-1:0] in_rdy;
   logic [STAGES-1:0] out_rdy;
   logic [WIDTH-1:0]  shifted;
   logic              deliver;
   logic [OW-1:0]     occ_sum;

   assign shifted = t0_data << SHIFT;

   // Ready propagates from the output back toward the input; in skid mode each
   // stage presents its own registered ready so the chain is broken at every stage.
   always_comb begin : ready_chain
      logic r;
      r = i0_ready;
      for (int s = STAGES - 1; s >= 0; s--) begin
         out_rdy[s] = r;
         in_rdy[s]  = (SKID != 0) ? rdy_q[s] : (~main_valid_q[s] | r);
         r          = in_rdy[s];
      end
      up_valid[0] = t0_valid;
      up_data[0]  = shifted;
      for (int s = 1; s < STAGES; s++) begin
         up_valid[s] = main_valid_q[s-1];
         up_data[s]  = main_data_q[s-1];
      end
   end

   always_comb begin : next_state
      logic acc;
      logic drn;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      for (int s = 0; s < STAGES; s++) begin
         main_data_d[s] = main_data_q[s];
         skid_data_d[s] = skid_data_q[s];
      end
      for (int s = 0; s < STAGES; s++) begin
         acc = up_valid[s] & in_rdy[s];
         drn = main_valid_q[s] & out_rdy[s];
         if (SKID != 0) begin
            if (drn) begin
               // A parked skid beat refills main in the same cycle main drains.
               if (skid_valid_q[s]) begin
                  main_data_d[s]  = skid_data_q[s];
                  skid_valid_d[s] = 1'b0;
               end else if (acc) begin
                  main_data_d[s] = up_data[s];
               end else begin
                  main_valid_d[s] = 1'b0;
               end
            end else if (acc) begin
               if (main_valid_q[s]) begin
                  skid_data_d[s]  = up_data[s];
                  skid_valid_d[s] = 1'b1;
               end else begin
                  main_data_d[s]  = up_data[s];
                  main_valid_d[s] = 1'b1;
               end
            end
         end else begin
            if (acc) begin
               main_data_d[s]  = up_data[s];
               main_valid_d[s] = 1'b1;
            end else if (drn) begin
               main_valid_d[s] = 1'b0;
            end
         end
      end
      rdy_d  = ~skid_valid_d;
      xfer_d = xfer_q + 16'(deliver);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid_q <= '0;
         skid_valid_q <= '0;
         rdy_q        <= '1;
         xfer_q       <= '0;
         for (int s = 0; s < STAGES; s++) begin
            main_data_q[s] <= '0;
            skid_data_q[s] <= '0;
         end
      end else if (flush) begin
         // Only the valid bits are dropped; data and the transfer count are left alone.
         main_valid_q <= '0;
         skid_valid_q <= '0;
         rdy_q        <= '1;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         rdy_q        <= rdy_d;
         xfer_q       <= xfer_d;
         for (int s = 0; s < STAGES; s++) begin
            main_data_q[s] <= main_data_d[s];
            skid_data_q[s] <= skid_data_d[s];
         end
      end
   end

   always_comb begin
      occ_sum = '0;
      for (int s = 0; s < STAGES; s++) begin
         occ_sum = occ_sum + OW'(main_valid_q[s]) + OW'(skid_valid_q[s]);
      end
   end

   assign t0_ready   = ~rst & ~flush & in_rdy[0];
   assign i0_valid   = ~rst & ~flush & main_valid_q[STAGES-1];
   assign i0_data    = main_data_q[STAGES-1];
   assign deliver    = i0_valid & i0_ready;
   assign occupancy  = occ_sum;
   assign xfer_count = xfer_q;

endmodule

// File: doc/elastic_shift_pipe.md
ELASTIC_SHIFT_PIPE -- requirements
Module: elastic_shift_pipe

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits; legal range 1..256.
REQ-002 Parameter STAGES, default 2, number of elastic register stages; legal range 1..8.
REQ-003 Parameter SHIFT, default 2, left-shift amount applied to each word; legal range 0..WIDTH-1.
REQ-004 Parameter SKID, default 1; 1 = each stage has a skid register and a registered ready, 0 = each stage uses a single register and combinational ready.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 t0_data  input  WIDTH  upstream data.
REQ-008 t0_valid  input  1  upstream data valid.
REQ-009 t0_ready  output  1  block accepts a beat this cycle.
REQ-010 i0_data  output  WIDTH  downstream data.
REQ-011 i0_valid  output  1  downstream data valid.
REQ-012 i0_ready  input  1  downstream accepts a beat this cycle.
REQ-013 flush  input  1  synchronous discard of all held beats.
REQ-014 occupancy  output  $clog2(2*STAGES+1)  number of beats currently held.
REQ-015 xfer_count  output  16  number of completed downstream transfers.

Function
REQ-016 A beat is accepted when t0_valid & t0_ready, and delivered when i0_valid & i0_ready.
REQ-017 Each delivered word equals the accepted t0_data shifted left by SHIFT and truncated to WIDTH bits, with zeros filled into the low SHIFT bits.
REQ-018 Beats are delivered in acceptance order, with no loss and no duplication.
REQ-019 Latency from acceptance to i0_valid is exactly STAGES cycles when no stage is stalled.
REQ-020 With i0_ready held at 1, the block sustains one accepted and one delivered beat per cycle in both SKID modes.
REQ-021 SKID=1: t0_ready is driven directly from a flop and equals NOT(first-stage skid register valid); there is no combinational path from i0_ready to t0_ready.
REQ-022 SKID=1, per stage: a beat arriving while the main register is held and its downstream is stalled goes to the skid register; when the main register drains, the skid contents move to the main register in that same cycle.
REQ-023 SKID=0, per stage: stage ready = NOT(stage valid) OR (downstream ready).
REQ-024 While i0_valid=1 and i0_ready=0, i0_data and i0_valid hold their values.
REQ-025 occupancy counts the valid main and skid registers; its maximum is 2*STAGES when SKID=1 and STAGES when SKID=0.
REQ-026 When the block is full, t0_ready=0 and occupancy stays at its maximum.
REQ-027 xfer_count increments by 1 on each delivered beat and wraps from 0xFFFF to 0x0000.
REQ-028 flush=1 forces t0_ready=0 and i0_valid=0 combinationally in that cycle, so no transfer occurs; all valid bits clear at the following edge.
REQ-029 flush does not change data registers or xfer_count.
REQ-030 flush and t0_valid asserted in the same cycle: the input beat is not accepted.
REQ-031 When occupancy is 0, i0_valid=0.
REQ-032 Simultaneous accept and deliver at the maximum occupancy is legal only when t0_ready=1; in that case occupancy is unchanged.

Reset
REQ-033 While rst=1 at a rising edge, all valid bits, data registers, occupancy and xfer_count are cleared to 0.
REQ-034 While rst=1, t0_ready=0 and i0_valid=0.
REQ-035 In the first cycle after rst deasserts, t0_ready=1.
REQ-036 Asserting rst mid-stream discards all held beats; no held beat is delivered after reset.
REQ-037 rst has priority over flush and over all handshakes.

Verification
REQ-038 Defaults, i0_ready=1, stream 0x1,0x2,0x40000001 -> i0_data 0x4,0x8,0x00000004 appear 2 cycles after each acceptance; xfer_count=3.
REQ-039 SKID=1, i0_ready=0, t0_valid held -> exactly 4 beats accepted, then t0_ready=0 with occupancy=4; release i0_ready -> 4 beats out in order, occupancy returns to 0.
REQ-040 SKID=0, STAGES=2, random valid/ready at 50% each, 10000 beats -> output matches a scoreboard, occupancy never exceeds 2, and t0_ready is combinationally consistent with REQ-023.
REQ-041 Fill with 3 beats, pulse flush one cycle together with t0_valid=1 -> no transfer in the flush cycle, occupancy=0 next cycle, xfer_count unchanged, and the flushed input beat is never seen.
REQ-042 Preload xfer_count to 0xFFFE via 65534 transfers, then deliver 3 beats -> xfer_count reads 0xFFFF, 0x0000, 0x0001.
REQ-043 Assert rst for 1 cycle with occupancy=3 -> next cycle occupancy=0, i0_valid=0, xfer_count=0, t0_ready=1, and no stale data is delivered afterwards.
